// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
//   - ALU operation codes driven on alu_op
//   - opcode (IR[31:26]) and funct (IR[5:0]) constants
//   - controller state enum
//   - alu_src_b and pc_src mux encodings
// Optional macro MC_JUMP_EN adds the JUMP state for the j instruction.
package mips_pkg;

   typedef enum logic [3:0] {
      AluAdd  = 4'd0,
      AluSub  = 4'd1,
      AluSlt  = 4'd2,
      AluSltu = 4'd3,
      AluAnd  = 4'd4,
      AluOr   = 4'd5,
      AluNor  = 4'd6,
      AluXor  = 4'd7,
      AluLui  = 4'd8
   } alu_op_e;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAddiu = 6'h09;
   localparam logic [5:0] OpSlti  = 6'h0a;
   localparam logic [5:0] OpSltiu = 6'h0b;
   localparam logic [5:0] OpAndi  = 6'h0c;
   localparam logic [5:0] OpOri   = 6'h0d;
   localparam logic [5:0] OpXori  = 6'h0e;
   localparam logic [5:0] OpLui   = 6'h0f;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2b;

   localparam logic [5:0] FnAdd   = 6'h20;
   localparam logic [5:0] FnAddu  = 6'h21;
   localparam logic [5:0] FnSub   = 6'h22;
   localparam logic [5:0] FnSubu  = 6'h23;
   localparam logic [5:0] FnAnd   = 6'h24;
   localparam logic [5:0] FnOr    = 6'h25;
   localparam logic [5:0] FnXor   = 6'h26;
   localparam logic [5:0] FnNor   = 6'h27;
   localparam logic [5:0] FnSlt   = 6'h2a;
   localparam logic [5:0] FnSltu  = 6'h2b;

   localparam logic [1:0] SrcBReg   = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
      StExecR, StExecI, StAluWb, StBranch, StHalt
`ifdef MC_JUMP_EN
      , StJump
`endif
   } state_e;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational instruction decoder for the multi-cycle controller.
//   op_i/funct_i : IR[31:26] / IR[5:0]
//   alu_op_o     : ALU operation for EXEC_R / EXEC_I
//   sz_en_o      : 1 sign-extend immediate, 0 zero-extend
//   legal_o      : instruction belongs to the supported set
// Optional macro MC_JUMP_EN makes op 0x02 (j) legal.
module mc_alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output logic [3:0] alu_op_o,
   output logic       sz_en_o,
   output logic       legal_o
);

   always_comb begin
      alu_op_o = AluAdd;
      sz_en_o  = 1'b0;
      legal_o  = 1'b1;
      case (op_i)
         OpRtype: begin
            case (funct_i)
               FnAdd, FnAddu: alu_op_o = AluAdd;
               FnSub, FnSubu: alu_op_o = AluSub;
               FnAnd:         alu_op_o = AluAnd;
               FnOr:          alu_op_o = AluOr;
               FnXor:         alu_op_o = AluXor;
               FnNor:         alu_op_o = AluNor;
               FnSlt:         alu_op_o = AluSlt;
               FnSltu:        alu_op_o = AluSltu;
               default:       legal_o  = 1'b0;
            endcase
         end
         OpLw, OpSw, OpBeq, OpBne: begin
         end
`ifdef MC_JUMP_EN
         OpJ: begin
         end
`endif
         OpAddi: begin
            alu_op_o = AluAdd;
            sz_en_o  = 1'b1;
         end
         OpAddiu: alu_op_o = AluAdd;
         OpSlti: begin
            alu_op_o = AluSlt;
            sz_en_o  = 1'b1;
         end
         OpSltiu: alu_op_o = AluSltu;
         OpAndi:  alu_op_o = AluAnd;
         OpOri:   alu_op_o = AluOr;
         OpXori:  alu_op_o = AluXor;
         OpLui:   alu_op_o = AluLui;
         default: legal_o  = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_mips_ctrl.sv
// Moore-style sequencer for a multi-cycle MIPS datapath with a shared,
// variable-latency memory (req/ready handshake guarded by a watchdog).
//   clk, reset        : clock, synchronous active-low reset
//   op, funct, zero   : IR fields and ALU zero flag
//   mem_ready         : memory completes the access this cycle
//   mem_req/mem_we/iord, ir_write, pc_write/pc_src : memory and PC control
//   alu_src_a/alu_src_b/alu_op/sz_en               : ALU control
//   reg_dst/mem_to_reg/reg_write                   : register file control
//   illegal_op        : one-cycle pulse in DECODE on an undecodable instruction
//   mem_err           : sticky memory-timeout fault (controller parks in HALT)
// Optional macro MC_JUMP_EN adds j decoding and the JUMP state.
module multicycle_mips_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [3:0] alu_op,
   output logic       sz_en,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal_op,
   output logic       mem_err
);

   // The fault fires on the cycle that would be the MEM_WAIT_MAX-th miss.
   localparam logic [7:0] WaitLast = 8'(MEM_WAIT_MAX - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       mem_err_q, mem_err_d;
   logic       mem_miss;
   logic [3:0] dec_alu_op;
   logic       dec_sz_en;
   logic       dec_legal;

   mc_alu_decoder u_alu_decoder (
      .op_i     (op),
      .funct_i  (funct),
      .alu_op_o (dec_alu_op),
      .sz_en_o  (dec_sz_en),
      .legal_o  (dec_legal)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StFetch;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign mem_err = mem_err_q;

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      mem_err_d  = mem_err_q;
      mem_miss   = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PcSrcAlu;
      alu_src_a  = 1'b0;
      alu_src_b  = SrcBReg;
      alu_op     = AluAdd;
      sz_en      = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;

      case (state_q)
         StFetch: begin
            mem_req   = 1'b1;
            alu_src_b = SrcBFour;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else begin
               mem_miss = 1'b1;
            end
         end
         StDecode: begin
            // Branch target (PC+4 + imm<<2) is parked in ALUOut here.
            alu_src_b = SrcBImmSh;
            sz_en     = 1'b1;
            if (!dec_legal) begin
               illegal_op = 1'b1;
               state_d    = StFetch;
            end else begin
               case (op)
                  OpLw, OpSw:   state_d = StMemAdr;
                  OpRtype:      state_d = StExecR;
                  OpBeq, OpBne: state_d = StBranch;
`ifdef MC_JUMP_EN
                  OpJ:          state_d = StJump;
`endif
                  default:      state_d = StExecI;
               endcase
            end
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = SrcBImm;
            sz_en     = 1'b1;
            state_d   = (op == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = StMemWb;
            else           mem_miss = 1'b1;
         end
         StMemWb: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = StFetch;
            else           mem_miss = 1'b1;
         end
         StExecR, StExecI: begin
            alu_src_a = 1'b1;
            alu_src_b = (state_q == StExecR) ? SrcBReg : SrcBImm;
            alu_op    = dec_alu_op;
            sz_en     = dec_sz_en;
            state_d   = StAluWb;
         end
         StAluWb: begin
            reg_write = 1'b1;
            reg_dst   = (op == OpRtype);
            state_d   = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = AluSub;
            pc_src    = PcSrcAluOut;
            pc_write  = ((op == OpBeq) & zero) | ((op == OpBne) & ~zero);
            state_d   = StFetch;
         end
`ifdef MC_JUMP_EN
         StJump: begin
            pc_write = 1'b1;
            pc_src   = PcSrcJump;
            state_d  = StFetch;
         end
`endif
         StHalt: begin
         end
         default: state_d = StFetch;
      endcase

      // Watchdog: a ready arriving on the limit cycle is handled above and wins.
      if (mem_miss) begin
         if (wait_q == WaitLast) begin
            state_d   = StHalt;
            mem_err_d = 1'b1;
         end else begin
            wait_d = wait_q + 8'd1;
         end
      end
      if (state_d != state_q) wait_d = '0;

      // Reset abandons any access: no strobe may leak out while it is held.
      if (!reset) begin
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_mips_ctrl.sv
module tb_multicycle_mips_ctrl;

   localparam int MaxWait = 4;

   localparam int CR = 0, CI = 1, CLW = 2, CSW = 3, CBR = 4, CJ = 5, CILL = 6;

   logic       clk, reset, zero, mem_ready;
   logic [5:0] op, funct;
   logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, sz_en;
   logic       reg_dst, mem_to_reg, reg_write, illegal_op, mem_err;
   logic [1:0] pc_src, alu_src_b;
   logic [3:0] alu_op;

   typedef struct packed {
      logic       req, we, iord, irw, pcw;
      logic [1:0] pcs;
      logic       a;
      logic [1:0] b;
      logic [3:0] alu;
      logic       sz, rdst, m2r, rw, ill, err;
   } outv_t;

   int n_checks = 0;
   int n_err    = 0;

   // Behavioural model: step index within the current instruction.
   int m_step = 0;
   int m_wait = 0;
   bit m_err  = 0;
   bit m_halt = 0;

   logic [5:0] r_fn  [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
   logic [3:0] r_alu [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd4, 4'd5, 4'd7, 4'd6, 4'd2, 4'd3};
   // I-ALU ops 0x08..0x0f in order.
   logic [3:0] i_alu [8]  = '{4'd0, 4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
   logic       i_sz  [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   multicycle_mips_ctrl #(.MEM_WAIT_MAX(MaxWait)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .sz_en      (sz_en),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .illegal_op (illegal_op),
      .mem_err    (mem_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int r_idx(input logic [5:0] f);
      for (int i = 0; i < 10; i++) if (r_fn[i] == f) return i;
      return -1;
   endfunction

   function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) return (r_idx(f) >= 0) ? CR : CILL;
      if (o == 6'h04 || o == 6'h05) return CBR;
      if (o == 6'h23) return CLW;
      if (o == 6'h2b) return CSW;
      if (o >= 6'h08 && o <= 6'h0f) return CI;
`ifdef MC_JUMP_EN
      if (o == 6'h02) return CJ;
`endif
      return CILL;
   endfunction

   // Number of the final step of each instruction class (fetch is step 0).
   function automatic int last_step(input int c);
      case (c)
         CLW:          return 4;
         CSW, CR, CI:  return 3;
         CBR, CJ:      return 2;
         default:      return 1;
      endcase
   endfunction

   function automatic bit is_mem(input int s, input int c);
      return (s == 0) || (s == 3 && (c == CLW || c == CSW));
   endfunction

   function automatic outv_t model_out();
      outv_t e = '0;
      int    c = cls_of(op, funct);
      e.err = m_err;
      if (m_halt) return e;
      case (m_step)
         0: begin
            e.req = 1; e.b = 2'b01;
            if (mem_ready) begin e.irw = 1; e.pcw = 1; end
         end
         1: begin
            e.b = 2'b11; e.sz = 1;
            if (c == CILL) e.ill = 1;
         end
         2: begin
            if (c == CLW || c == CSW) begin e.a = 1; e.b = 2'b10; e.sz = 1; end
            else if (c == CR) begin e.a = 1; e.alu = r_alu[r_idx(funct)]; end
            else if (c == CI) begin
               e.a = 1; e.b = 2'b10;
               e.alu = i_alu[op - 6'h08]; e.sz = i_sz[op - 6'h08];
            end else if (c == CBR) begin
               e.a = 1; e.alu = 4'd1; e.pcs = 2'b01;
               e.pcw = (op == 6'h04) ? zero : !zero;
            end else if (c == CJ) begin
               e.pcw = 1; e.pcs = 2'b10;
            end
         end
         3: begin
            if (c == CLW) begin e.req = 1; e.iord = 1; end
            else if (c == CSW) begin e.req = 1; e.we = 1; e.iord = 1; end
            else begin e.rw = 1; e.rdst = (op == 6'h00); end
         end
         default: begin
            e.rw = 1; e.m2r = 1;
         end
      endcase
      if (!reset) begin e.req = 0; e.we = 0; e.irw = 0; e.pcw = 0; e.rw = 0; end
      return e;
   endfunction

   task automatic model_update();
      int c = cls_of(op, funct);
      if (!reset) begin
         m_step = 0; m_wait = 0; m_err = 0; m_halt = 0;
         return;
      end
      if (m_halt) return;
      if (is_mem(m_step, c) && !mem_ready) begin
         m_wait++;
         if (m_wait == MaxWait) begin m_halt = 1; m_err = 1; end
         return;
      end
      m_step = (m_step >= last_step(c)) ? 0 : m_step + 1;
      if (is_mem(m_step, c)) m_wait = 0;
   endtask

   // Sample on the falling edge and compare every output against the model.
   task automatic at_neg();
      outv_t act, exp_v;
      @(negedge clk);
      act = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
             alu_op, sz_en, reg_dst, mem_to_reg, reg_write, illegal_op, mem_err};
      exp_v = model_out();
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL outputs t=%0t step=%0d op=%h funct=%h: actual=%b required=%b",
                  $time, m_step, op, funct, act, exp_v);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic cyc();
      at_neg();
      adv();
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s t=%0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   int hcnt = 0;
   int r;

   initial begin
      reset = 0; op = 6'h00; funct = 6'h20; zero = 0; mem_ready = 1;
      adv();
      at_neg(); chk("rst_mem_req", mem_req, 0); chk("rst_pc_write", pc_write, 0); adv();

      // add $3,$1,$2
      reset = 1;
      at_neg(); chk("add_c1_pcw", pc_write, 1); chk("add_c1_irw", ir_write, 1); adv();
      at_neg(); chk("add_c2_pcw", pc_write, 0); chk("add_c2_srcb", alu_src_b, 3); adv();
      at_neg(); chk("add_c3_srca", alu_src_a, 1); chk("add_c3_alu", alu_op, 0); adv();
      at_neg(); chk("add_c4_rw", reg_write, 1); chk("add_c4_rdst", reg_dst, 1); adv();

      // lw with three stalled MEMRD cycles: 8 cycles total
      op = 6'h23;
      at_neg(); chk("lw_c1_fetch", mem_req, 1); adv();
      cyc(); cyc();
      mem_ready = 0;
      at_neg(); chk("lw_c4_iord", iord, 1); chk("lw_c4_req", mem_req, 1); adv();
      cyc(); cyc();
      mem_ready = 1;
      cyc();
      at_neg(); chk("lw_c8_rw", reg_write, 1); chk("lw_c8_m2r", mem_to_reg, 1); adv();
      at_neg(); chk("lw_c9_fetch_iord", iord, 0); chk("lw_c9_fetch_req", mem_req, 1); adv();

      // beq taken / bne not taken with zero=1
      op = 6'h04; zero = 1;
      cyc();
      at_neg(); chk("beq_pcw", pc_write, 1); chk("beq_pcsrc", pc_src, 1); adv();
      op = 6'h05;
      cyc(); cyc();
      at_neg(); chk("bne_pcw", pc_write, 0); adv();

      // illegal opcode, then watchdog in FETCH
      op = 6'h3f; zero = 0;
      cyc();
      at_neg(); chk("ill_pulse", illegal_op, 1); chk("ill_rw", reg_write, 0); adv();
      mem_ready = 0;
      at_neg(); chk("ill_next_fetch", mem_req, 1); chk("ill_gone", illegal_op, 0); adv();
      repeat (3) cyc();
      at_neg(); chk("wd_err", mem_err, 1); chk("wd_halt_req", mem_req, 0); adv();
      mem_ready = 1;
      repeat (3) cyc();
      at_neg(); chk("halt_sticky", mem_err, 1); chk("halt_pcw", pc_write, 0); adv();

      // reset clears fault; then sw interrupted by reset in MEMWR
      reset = 0; op = 6'h2b;
      cyc();
      reset = 1;
      at_neg(); chk("rst_err_clr", mem_err, 0); chk("rst_fetch", mem_req, 1); adv();
      cyc(); cyc();
      reset = 0;
      at_neg(); chk("sw_rst_we", mem_we, 0); chk("sw_rst_req", mem_req, 0); adv();
      reset = 1;
      at_neg(); chk("sw_after_fetch", iord, 0); chk("sw_after_req", mem_req, 1); adv();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if (m_step == 0) begin
            r = $urandom_range(0, 15);
            if (r <= 4) begin op = 6'h00; funct = r_fn[$urandom_range(0, 9)]; end
            else if (r == 5) begin op = 6'h00; funct = 6'($urandom_range(0, 31)); end
            else if (r <= 7) op = 6'h23;
            else if (r <= 9) op = 6'h2b;
            else if (r <= 11) op = 6'($urandom_range(4, 5));
            else if (r <= 14) op = 6'($urandom_range(8, 15));
            else begin op = 6'($urandom_range(0, 63)); funct = 6'($urandom_range(0, 63)); end
         end
         mem_ready = ($urandom_range(0, 9) < 6);
         zero      = 1'($urandom_range(0, 1));
         if (m_halt) hcnt++;
         if (hcnt > 3) begin
            reset = 0; hcnt = 0;
         end else begin
            reset = ($urandom_range(0, 99) != 0);
         end
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_mips_ctrl.md
Name: multicycle_mips_ctrl

Overview:
Moore-style FSM controller that sequences a multi-cycle MIPS datapath. The datapath has a shared instruction/data memory, IR, A/B and ALUOut registers, and the existing register file and ALU. It covers the same instruction set as the single-cycle core: R add(u)/sub(u)/and/or/xor/nor/slt/sltu; I beq/bne/lw/sw/addi(u)/slti(u)/andi/ori/xori/lui. Memory accesses use a req/ready handshake with a watchdog, so the controller tolerates variable-latency memory.

Parameters:
MEM_WAIT_MAX, 15, max cycles mem_req may stay high without mem_ready before fault (1..255)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe (valid with mem_req)
iord  out  1  0=address PC, 1=address ALUOut
ir_write  out  1  load IR from read data
pc_write  out  1  load PC
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
alu_src_a  out  1  0=PC, 1=A reg
alu_src_b  out  2  00 B reg, 01 const 4, 10 Imm32, 11 Imm32<<2
alu_op  out  4  ADD0 SUB1 SLT2 SLTU3 AND4 OR5 NOR6 XOR7 LUI8
sz_en  out  1  1 sign-extend, 0 zero-extend
reg_dst  out  1  1 rd, 0 rt
mem_to_reg  out  1  1 memory data, 0 ALUOut
reg_write  out  1  register file write enable
illegal_op  out  1  one-cycle pulse on an undecodable instruction
mem_err  out  1  sticky memory-timeout fault

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, HALT (+JUMP if enabled).
- Reset (reset==0 at edge): next state FETCH, wait counter 0, mem_err 0. While reset is low, all enables are forced 0: mem_req, mem_we, ir_write, pc_write, reg_write. Reset mid-access abandons the access with no write.
- FETCH: mem_req=1, iord=0, src_a=0, src_b=01, alu_op=ADD. On mem_ready: ir_write=1, pc_write=1, pc_src=00, next DECODE. Otherwise stay.
- DECODE: src_a=0, src_b=11, sz_en=1, ADD (branch target into ALUOut).
  - lw/sw -> MEMADR; R-type -> EXEC_R; beq/bne -> BRANCH; I-ALU -> EXEC_I.
  - Unknown op, or op=0 with unknown funct: illegal_op=1 for that cycle, next FETCH, no writes.
- MEMADR: src_a=1, src_b=10, sz_en=1, ADD. Next MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1. On mem_ready -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. On mem_ready -> FETCH.
- EXEC_R: src_a=1, src_b=00, alu_op from funct (addu=ADD, subu=SUB). Next ALUWB.
- EXEC_I: src_a=1, src_b=10, alu_op from op.
  - sz_en=1 for addi/slti; 0 for addiu/sltiu/andi/ori/xori/lui.
  - Next ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0. reg_dst=1 if op==0, else 0. Next FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01. pc_write = (beq & zero) | (bne & ~zero), a Mealy output on zero. Next FETCH.
- Latency with mem_ready immediate: branch 3, R/I/sw 4, lw 5 cycles. Each cycle of mem_ready low adds one cycle.
- Watchdog: counter clears on entry to any memory state. It increments each cycle mem_req=1 && mem_ready=0. When it reaches MEM_WAIT_MAX: mem_err<=1, next HALT.
  - mem_ready in the same cycle as the limit wins: no fault.
- HALT: all outputs 0; exit only via reset.
- Outputs not listed for a state are 0. In non-ALU states alu_op=ADD, alu_src_* = 0.

Optional Feature:
MC_JUMP_EN: when defined, j (op 0x02) is decoded. DECODE -> JUMP; JUMP asserts pc_write=1, pc_src=10; next FETCH (3 cycles). When undefined, op 0x02 is illegal (illegal_op pulse) and pc_src=10 is never driven.

Decomposition:
- Package mips_pkg holds:
  - ALU op codes (ADD..LUI)
  - opcode and funct constants
  - state enum
  - alu_src_b and pc_src encodings
- One natural sub-module: mc_alu_decoder, combinational op/funct -> alu_op, sz_en, legal. The FSM instantiates it for EXEC_R/EXEC_I and for the DECODE legality check.

Test Plan:
- Release reset, mem_ready=1, IR=add $3,$1,$2 -> FETCH,DECODE,EXEC_R,ALUWB; reg_write/reg_dst=1 in cycle 4; PC write only in cycle 1.
- lw with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB reg_write=1 mem_to_reg=1, total 8 cycles.
- beq zero=1 -> pc_write=1 pc_src=01 in BRANCH; bne zero=1 -> pc_write=0.
- op=0x3F -> illegal_op pulse in DECODE, next FETCH, no reg_write/mem_we.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in FETCH -> mem_err=1 after 4 cycles, HALT, stays until reset low.
- reset low during MEMWR -> mem_we=0 that cycle, FETCH next, mem_err cleared.
